// File: rtl/patp_pkg.sv
// Shared definitions for the PATP control sequencer: opcodes, FSM states,
// ALU operation codes and MAR source selects.
package patp_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC0  = 3'd3,
    ST_EXEC1  = 3'd4,
    ST_HALT   = 3'd5,
    ST_STEP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_t;

  localparam logic MAR_SEL_PC = 1'b0;
  localparam logic MAR_SEL_IR = 1'b1;

endpackage

// File: rtl/patp_op_decode.sv
// Combinational opcode classifier: splits the 3-bit opcode into the
// instruction classes the sequencer branches on, plus the ALU operation.
module patp_op_decode
  import patp_pkg::*;
(
  input  logic [2:0] i_op,
  output logic       o_is_mem_rd,
  output logic       o_is_store,
  output logic       o_is_jump,
  output logic       o_is_cond,
  output logic       o_is_halt,
  output alu_op_t    o_alu_op
);

  always_comb begin
    o_is_mem_rd = 1'b0;
    o_is_store  = 1'b0;
    o_is_jump   = 1'b0;
    o_is_cond   = 1'b0;
    o_is_halt   = 1'b0;
    o_alu_op    = ALU_PASS;
    unique case (i_op)
      OP_LOAD:  o_is_mem_rd = 1'b1;
      OP_STORE: o_is_store  = 1'b1;
      OP_ADD: begin
        o_is_mem_rd = 1'b1;
        o_alu_op    = ALU_ADD;
      end
      OP_SUB: begin
        o_is_mem_rd = 1'b1;
        o_alu_op    = ALU_SUB;
      end
      OP_JMP:  o_is_jump = 1'b1;
      OP_JZ: begin
        o_is_jump = 1'b1;
        o_is_cond = 1'b1;
      end
      OP_NOP:  ;
      OP_HALT: o_is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/patp_ctrl.sv
// PATP fetch/execute sequencer; owns every datapath strobe.
// Optional single-step mode is enabled by defining PATP_SINGLE_STEP_EN.
module patp_ctrl
  import patp_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 3
) (
  input  logic            clk,
  input  logic            rst,
`ifdef PATP_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [OP_W-1:0] ir_opcode,
  input  logic            acc_zero,
  input  logic            mem_ready,
  output logic            mar_we,
  output logic            mar_sel,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            ir_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            acc_we,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            retire
);

  // The opcode field sits directly above the address field in an 8-bit IR.
  if (OP_W != 3 || ADDR_W + OP_W != 8) begin : g_bad_ir_layout
    $error("patp_ctrl expects a 3-bit opcode above a 5-bit address");
  end

  state_t  r_state;
  state_t  w_next;
  state_t  w_after_retire;
  logic    w_is_mem_rd;
  logic    w_is_store;
  logic    w_is_jump;
  logic    w_is_cond;
  logic    w_is_halt;
  alu_op_t w_alu_op;

  patp_op_decode u_op_decode (
    .i_op        (ir_opcode[2:0]),
    .o_is_mem_rd (w_is_mem_rd),
    .o_is_store  (w_is_store),
    .o_is_jump   (w_is_jump),
    .o_is_cond   (w_is_cond),
    .o_is_halt   (w_is_halt),
    .o_alu_op    (w_alu_op)
  );

`ifdef PATP_SINGLE_STEP_EN
  assign w_after_retire = ST_STEP;
`else
  assign w_after_retire = ST_FETCH0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= w_after_retire;
    else     r_state <= w_next;
  end

  // NOTE: every output and w_next gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next  = r_state;
    mar_we  = 1'b0;
    mar_sel = MAR_SEL_PC;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    ir_we   = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    acc_we  = 1'b0;
    alu_op  = ALU_PASS;
    halted  = 1'b0;
    retire  = 1'b0;
    // Reset gates every strobe so an in-flight access drops immediately.
    if (!rst) begin
      unique case (r_state)
        ST_FETCH0: begin
          mar_we = 1'b1;
          w_next = ST_FETCH1;
        end
        ST_FETCH1: begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we  = 1'b1;
            pc_inc = 1'b1;
            w_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_is_mem_rd || w_is_store) begin
            w_next = ST_EXEC0;
          end else begin
            retire  = 1'b1;
            pc_load = w_is_jump && (!w_is_cond || acc_zero);
            w_next  = w_is_halt ? ST_HALT : w_after_retire;
          end
        end
        ST_EXEC0: begin
          mar_sel = MAR_SEL_IR;
          mar_we  = 1'b1;
          w_next  = ST_EXEC1;
        end
        ST_EXEC1: begin
          mar_sel = MAR_SEL_IR;
          mem_we  = w_is_store;
          mem_re  = !w_is_store;
          if (mem_ready) begin
            retire = 1'b1;
            acc_we = w_is_mem_rd;
            alu_op = w_alu_op;
            w_next = w_after_retire;
          end
        end
        ST_HALT: halted = 1'b1;
`ifdef PATP_SINGLE_STEP_EN
        ST_STEP: if (step) w_next = ST_FETCH0;
`endif
        default: w_next = ST_FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_patp_ctrl.sv
// Self-checking bench for patp_ctrl: builds an expected per-cycle trace from
// instruction-level timing rules, then replays and compares it cycle by cycle.
module tb_patp_ctrl;

  localparam logic [2:0] T_LOAD = 3'd0, T_STORE = 3'd1, T_ADD = 3'd2, T_SUB = 3'd3;
  localparam logic [2:0] T_JMP = 3'd4, T_JZ = 3'd5, T_NOP = 3'd6, T_HALT = 3'd7;

  // Output vector layout: mar_we mar_sel pc_inc pc_load ir_we mem_re mem_we
  // acc_we alu_op[1:0] halted retire
  localparam logic [11:0] O_MARWE  = 12'h800;
  localparam logic [11:0] O_MARSEL = 12'h400;
  localparam logic [11:0] O_PCINC  = 12'h200;
  localparam logic [11:0] O_PCLD   = 12'h100;
  localparam logic [11:0] O_IRWE   = 12'h080;
  localparam logic [11:0] O_MEMRE  = 12'h040;
  localparam logic [11:0] O_MEMWE  = 12'h020;
  localparam logic [11:0] O_ACCWE  = 12'h010;
  localparam logic [11:0] O_ALUADD = 12'h004;
  localparam logic [11:0] O_ALUSUB = 12'h008;
  localparam logic [11:0] O_HALTED = 12'h002;
  localparam logic [11:0] O_RETIRE = 12'h001;
  localparam logic [11:0] M_ALL    = 12'hFFF;
  localparam logic [11:0] M_STD    = 12'hFF3;  // alu_op only matters with acc_we
  localparam logic [11:0] M_NOSEL  = 12'hBF3;  // mar_sel free outside FETCH/EXEC

  typedef struct {
    logic        rst;
    logic        step;
    logic [2:0]  op;
    logic        az;
    logic        rdy;
    logic [11:0] exp;
    logic [11:0] mask;
    string       tag;
  } vec_t;

  vec_t q[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic [2:0] ir_opcode = 3'd0;
  logic       acc_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mar_we, mar_sel, pc_inc, pc_load, ir_we, mem_re, mem_we;
  logic       acc_we, halted, retire;
  logic [1:0] alu_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  patp_ctrl #(.ADDR_W(5), .OP_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PATP_SINGLE_STEP_EN
    .step      (step),
`endif
    .ir_opcode (ir_opcode),
    .acc_zero  (acc_zero),
    .mem_ready (mem_ready),
    .mar_we    (mar_we),
    .mar_sel   (mar_sel),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .ir_we     (ir_we),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .acc_we    (acc_we),
    .alu_op    (alu_op),
    .halted    (halted),
    .retire    (retire)
  );

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  // step is don't-care outside STEP, so it is randomised when the port exists.
  function automatic logic rstep();
`ifdef PATP_SINGLE_STEP_EN
    return rbit();
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push(input logic r, input logic st, input logic [2:0] op,
                               input logic az, input logic rdy, input logic [11:0] e,
                               input logic [11:0] m, input string tag);
    vec_t v;
    v.rst = r; v.step = st; v.op = op; v.az = az; v.rdy = rdy;
    v.exp = e; v.mask = m; v.tag = tag;
    q.push_back(v);
  endfunction

  // Single-step wait after reset/retire: n idle cycles then a step pulse.
  function automatic void gen_step(input int n);
`ifdef PATP_SINGLE_STEP_EN
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, rop(), rbit(), rbit(), 12'h000, M_ALL, "step_idle");
    push(1'b0, 1'b1, rop(), rbit(), rbit(), 12'h000, M_ALL, "step_go");
`endif
  endfunction

  function automatic void gen_reset();
    push(1'b1, rstep(), rop(), rbit(), rbit(), 12'h000, M_ALL, "rst");
    gen_step($urandom_range(0, 3));
  endfunction

  function automatic void gen_fetch(input int wf);
    push(1'b0, rstep(), rop(), rbit(), rbit(), O_MARWE, M_STD, "fetch0");
    for (int i = 0; i < wf; i++) push(1'b0, rstep(), rop(), rbit(), 1'b0, O_MEMRE, M_STD, "fetch1_wait");
    push(1'b0, rstep(), rop(), rbit(), 1'b1, O_MEMRE | O_IRWE | O_PCINC, M_STD, "fetch1_done");
  endfunction

  // Whole instruction: fetch with wf waits, execute with we waits.
  function automatic void gen_instr(input logic [2:0] op, input int wf, input int we,
                                    input logic az);
    logic        is_mem;
    logic [11:0] dec_exp;
    logic [11:0] strobe;
    logic [11:0] fin;
    gen_fetch(wf);
    is_mem = (op <= T_SUB);
    case (op)
      T_JMP:   dec_exp = O_PCLD | O_RETIRE;
      T_JZ:    dec_exp = (az ? O_PCLD : 12'h000) | O_RETIRE;
      T_NOP:   dec_exp = O_RETIRE;
      T_HALT:  dec_exp = O_RETIRE;
      default: dec_exp = 12'h000;
    endcase
    push(1'b0, rstep(), op, az, rbit(), dec_exp, M_NOSEL, "decode");
    if (is_mem) begin
      strobe = (op == T_STORE) ? O_MEMWE : O_MEMRE;
      push(1'b0, rstep(), op, rbit(), rbit(), O_MARWE | O_MARSEL, M_STD, "exec0");
      for (int i = 0; i < we; i++)
        push(1'b0, rstep(), op, rbit(), 1'b0, O_MARSEL | strobe, M_STD, "exec1_wait");
      fin = O_MARSEL | strobe | O_RETIRE;
      if (op == T_ADD) fin |= O_ACCWE | O_ALUADD;
      if (op == T_SUB) fin |= O_ACCWE | O_ALUSUB;
      if (op == T_LOAD) fin |= O_ACCWE;
      push(1'b0, rstep(), op, rbit(), 1'b1, fin, (op == T_STORE) ? M_STD : M_ALL, "exec1_done");
    end
    if (op != T_HALT) gen_step($urandom_range(0, 3));
  endfunction

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] exp, input logic [11:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s: got %03h expected %03h (mask %03h) at %0t", name, act, exp, mask, $time);
    end
  endtask

  initial begin
    logic [11:0] act;

    // Reset state
    push(1'b1, rstep(), rop(), rbit(), rbit(), 12'h000, M_ALL, "rst_hold");
    gen_reset();

    // Reset during FETCH1 with memory stalled, then normal fetch resumes
    push(1'b0, rstep(), rop(), rbit(), rbit(), O_MARWE, M_STD, "fetch0");
    push(1'b0, rstep(), rop(), rbit(), 1'b0, O_MEMRE, M_STD, "fetch1_wait");
    push(1'b0, rstep(), rop(), rbit(), 1'b0, O_MEMRE, M_STD, "fetch1_wait");
    gen_reset();

    // Directed instructions
    gen_instr(T_LOAD, 0, 0, 1'b0);
    gen_instr(T_STORE, 0, 2, 1'b0);
    gen_instr(T_JZ, 0, 0, 1'b1);
    gen_instr(T_JZ, 0, 0, 1'b0);
    gen_instr(T_JMP, 1, 0, 1'b0);
    gen_instr(T_NOP, 0, 0, 1'b1);
    gen_instr(T_ADD, 2, 1, 1'b0);
    gen_instr(T_SUB, 0, 3, 1'b1);

    // Reset during EXEC1 of a stalled LOAD: no acc_we, read drops
    gen_fetch(0);
    push(1'b0, rstep(), T_LOAD, rbit(), rbit(), 12'h000, M_NOSEL, "decode");
    push(1'b0, rstep(), T_LOAD, rbit(), rbit(), O_MARWE | O_MARSEL, M_STD, "exec0");
    push(1'b0, rstep(), T_LOAD, rbit(), 1'b0, O_MARSEL | O_MEMRE, M_STD, "exec1_wait");
    push(1'b1, rstep(), T_LOAD, rbit(), 1'b1, 12'h000, M_ALL, "rst_exec");
    gen_step(2);

    // Long single-step hold before an ADD (no-op without the step port)
    gen_step(10);
    gen_instr(T_ADD, 0, 0, 1'b0);

    // Randomised instruction stream
    for (int i = 0; i < 120; i++)
      gen_instr(3'($urandom_range(0, 6)), $urandom_range(0, 3), $urandom_range(0, 3), rbit());

    // HALT: parked for 20 cycles with mem_ready toggling, then reset exits
    gen_instr(T_HALT, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      push(1'b0, rstep(), rop(), rbit(), 1'(i % 2), O_HALTED, M_NOSEL, "halted");
    gen_reset();
    gen_instr(T_LOAD, 1, 1, 1'b0);

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      rst       = q[i].rst;
      step      = q[i].step;
      ir_opcode = q[i].op;
      acc_zero  = q[i].az;
      mem_ready = q[i].rdy;
      @(negedge clk);
      act = {mar_we, mar_sel, pc_inc, pc_load, ir_we, mem_re, mem_we, acc_we,
             alu_op, halted, retire};
      check(q[i].tag, act, q[i].exp, q[i].mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
